// File: rtl/fifo_burst_reader_if.sv
// -----------------------------------------------------------------------------
// fifo_burst_reader_if
// Groups the FIFO-side and downstream-side signals of fifo_burst_reader.
//
//   fifo_empty     FIFO empty flag
//   fifo_threshold FIFO threshold flag
//   fifo_data      FIFO read data, valid the cycle after fifo_rd
//   fifo_rd        FIFO read strobe, one read per high cycle
//   m_valid        downstream data valid
//   m_ready        downstream ready
//   m_data         downstream data
//
// Downstream handshake: a beat transfers on a rising clk edge where m_valid
// and m_ready are both high. Once m_valid is high, m_valid and m_data hold
// stable until that transfer; m_ready may change freely.
//
// Modports: master = the burst reader, slave = the FIFO/sink side.
// -----------------------------------------------------------------------------
interface fifo_burst_reader_if #(
   parameter int DATA_W = 8
);
   logic              fifo_empty;
   logic              fifo_threshold;
   logic [DATA_W-1:0] fifo_data;
   logic              fifo_rd;
   logic              m_valid;
   logic              m_ready;
   logic [DATA_W-1:0] m_data;

   modport master (
      input  fifo_empty,
      input  fifo_threshold,
      input  fifo_data,
      output fifo_rd,
      output m_valid,
      input  m_ready,
      output m_data
   );

   modport slave (
      output fifo_empty,
      output fifo_threshold,
      output fifo_data,
      input  fifo_rd,
      input  m_valid,
      output m_ready,
      input  m_data
   );
endinterface

// File: rtl/fifo_burst_reader.sv
// -----------------------------------------------------------------------------
// fifo_burst_reader
// Reads bursts of BURST_LEN words from a FIFO when its threshold flag is up,
// or drains it completely on a flush request, and forwards the words through
// a 2-entry skid buffer to a valid/ready downstream port.
//
// Ports:
//   clk            single clock, rising edge
//   rst_n          asynchronous active-low reset
//   flush          single-cycle request to drain the FIFO completely
//   bus            fifo_burst_reader_if.master (FIFO read side + downstream)
//   busy           high whenever the FSM is not IDLE
//   underflow_err  sticky; set if fifo_rd is ever high while fifo_empty is high
//   state_dbg      current FSM state (IDLE=0, BURST=1, FLUSH=2, DRAIN=3)
// -----------------------------------------------------------------------------
module fifo_burst_reader #(
   parameter int DATA_W    = 8,
   parameter int BURST_LEN = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 flush,
   fifo_burst_reader_if.master  bus,
   output logic                 busy,
   output logic                 underflow_err,
   output logic [1:0]           state_dbg
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_BURST = 2'd1;
   localparam logic [1:0] S_FLUSH = 2'd2;
   localparam logic [1:0] S_DRAIN = 2'd3;

   localparam logic [7:0] BURST_END  = 8'(BURST_LEN);
   localparam logic [7:0] BURST_LAST = 8'(BURST_LEN - 1);

   logic [1:0]        state;
   logic [1:0]        state_nxt;
   logic [7:0]        burst_cnt;
   logic              flush_pend;
   logic              rd_q;        // a read was issued last cycle; data arrives now
   logic [DATA_W-1:0] buf_mem [2];
   logic              wr_ptr;
   logic              rd_ptr;
   logic [1:0]        count;
   logic              xfer;
   logic              read_phase;
   logic              rd_issue;
   logic [1:0]        load_after;

   assign xfer = (count != 2'd0) && bus.m_ready;

   // Buffer load once this cycle's downstream transfer is taken out, with the
   // in-flight read counted as already occupying a slot. Discounting the beat
   // leaving this cycle is what lets a read issue every cycle while m_ready is
   // held high; a new read is still only issued when a slot is guaranteed.
   assign load_after = count + {1'b0, rd_q} - {1'b0, xfer};

   assign read_phase = ((state == S_BURST) && (burst_cnt != BURST_END)) ||
                       (state == S_FLUSH);

   assign rd_issue = read_phase && !bus.fifo_empty && (load_after < 2'd2);

   assign bus.fifo_rd  = rd_issue;
   assign bus.m_valid  = (count != 2'd0);
   assign bus.m_data   = buf_mem[rd_ptr];
   assign busy         = (state != S_IDLE);
   assign state_dbg    = state;

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            // Flush wins over a burst start.
            if (flush || flush_pend)
               state_nxt = S_FLUSH;
            else if (bus.fifo_threshold && !bus.fifo_empty)
               state_nxt = S_BURST;
         end
         S_BURST: begin
            if (rd_issue && (burst_cnt == BURST_LAST))
               state_nxt = S_DRAIN;
         end
         S_FLUSH: begin
            if (bus.fifo_empty && !rd_q)
               state_nxt = S_DRAIN;
         end
         S_DRAIN: begin
            if ((count == 2'd0) && !rd_q)
               state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= S_IDLE;
         burst_cnt     <= 8'd0;
         flush_pend    <= 1'b0;
         rd_q          <= 1'b0;
         underflow_err <= 1'b0;
      end else begin
         state <= state_nxt;
         rd_q  <= rd_issue;

         if ((state == S_IDLE) && (state_nxt == S_BURST))
            burst_cnt <= 8'd0;
         else if ((state == S_BURST) && rd_issue && (burst_cnt != 8'hFF))
            burst_cnt <= burst_cnt + 8'd1;

         // FLUSH is only entered from IDLE, so that is the only clear point.
         if ((state == S_IDLE) && (state_nxt == S_FLUSH))
            flush_pend <= 1'b0;
         else if (flush && (state != S_IDLE))
            flush_pend <= 1'b1;

         if (bus.fifo_rd && bus.fifo_empty)
            underflow_err <= 1'b1;
      end
   end

   // Skid buffer: capture one cycle after each read, pop on transfer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         buf_mem[0] <= '0;
         buf_mem[1] <= '0;
         wr_ptr     <= 1'b0;
         rd_ptr     <= 1'b0;
         count      <= 2'd0;
      end else begin
         if (rd_q) begin
            buf_mem[wr_ptr] <= bus.fifo_data;
            wr_ptr          <= ~wr_ptr;
         end
         if (xfer)
            rd_ptr <= ~rd_ptr;
         count <= load_after;
      end
   end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// -----------------------------------------------------------------------------
// tb_fifo_burst_reader
// Bench for fifo_burst_reader: a small FIFO model feeds the reader, expected
// beats are queued as words are written, and a negedge monitor pops and
// compares every downstream transfer.
// -----------------------------------------------------------------------------
module tb_fifo_burst_reader;

   localparam int DATA_W    = 8;
   localparam int BURST_LEN = 4;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc = cyc + 1;

   // ---------------- DUT ----------------
   fifo_burst_reader_if #(.DATA_W(DATA_W)) bus ();
   logic       flush;
   logic       busy;
   logic       underflow_err;
   logic [1:0] state_dbg;

   fifo_burst_reader #(.DATA_W(DATA_W), .BURST_LEN(BURST_LEN)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .flush         (flush),
      .bus           (bus.master),
      .busy          (busy),
      .underflow_err (underflow_err),
      .state_dbg     (state_dbg)
   );

   // ---------------- FIFO model ----------------
   logic [7:0] fmem [64];
   logic [5:0] f_wr = 6'd0;
   logic [5:0] f_rd = 6'd0;
   logic       fifo_clr = 1'b0;

   assign bus.fifo_empty = (f_wr == f_rd);

   always @(posedge clk) begin
      if (fifo_clr)
         f_rd <= f_wr;
      else if (bus.fifo_rd) begin
         bus.fifo_data <= fmem[f_rd];
         f_rd          <= f_rd + 6'd1;
      end
   end

   // ---------------- scoreboard ----------------
   logic [7:0] exp_q [$];
   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp_v);
      n_checks++;
      if (got !== exp_v) begin
         n_errors++;
         $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp_v);
      end
   endtask

   // ---------------- monitor ----------------
   int         rd_pulses = 0;
   int         beats     = 0;
   bit         chk_gap   = 1'b0;
   bit         have_prev = 1'b0;
   int         last_cyc  = 0;
   logic       prev_valid = 1'b0;
   logic       prev_ready = 1'b0;
   logic [7:0] prev_data  = 8'h00;

   always @(negedge clk) begin
      if (bus.fifo_rd)
         rd_pulses = rd_pulses + 1;
      if (!chk_gap)
         have_prev = 1'b0;
      if (rst_n) begin
         if (prev_valid && !prev_ready) begin
            check("hold_valid", bus.m_valid, 1'b1);
            check("hold_data", bus.m_data, prev_data);
         end
         if (bus.m_valid && bus.m_ready) begin
            beats = beats + 1;
            if (exp_q.size() == 0)
               check("unexpected_beat", 1, 0);
            else
               check("m_data", bus.m_data, exp_q.pop_front());
            if (chk_gap) begin
               if (have_prev)
                  check("beat_gap", cyc - last_cyc, 1);
               have_prev = 1'b1;
               last_cyc  = cyc;
            end
         end
      end
      prev_valid = bus.m_valid;
      prev_ready = bus.m_ready;
      prev_data  = bus.m_data;
   end

   // ---------------- driver tasks ----------------
   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic push_fifo(input logic [7:0] v, input bit expect_out);
      fmem[f_wr] = v;
      f_wr = f_wr + 6'd1;
      if (expect_out)
         exp_q.push_back(v);
   endtask

   task automatic clear_fifo();
      fifo_clr = 1'b1;
      step(1);
      fifo_clr = 1'b0;
   endtask

   task automatic pulse_threshold();
      bus.fifo_threshold = 1'b1;
      step(1);
      bus.fifo_threshold = 1'b0;
   endtask

   task automatic pulse_flush();
      flush = 1'b1;
      step(1);
      flush = 1'b0;
   endtask

   // Wait until every expected beat is out and the reader is idle.
   task automatic wait_done(input string tag, input int max_cyc);
      bit done = 1'b0;
      for (int i = 0; i < max_cyc; i++) begin
         @(negedge clk);
         if (exp_q.size() == 0 && !busy) begin
            done = 1'b1;
            break;
         end
      end
      check(tag, done, 1'b1);
      step(1);
   endtask

   // ---------------- stimulus ----------------
   int c0;
   int rd_base;
   int beat_base;
   int busy_cnt;
   int seen;

   initial begin
      rst_n              = 1'b0;
      flush              = 1'b0;
      bus.fifo_threshold = 1'b0;
      bus.m_ready        = 1'b1;
      bus.fifo_data      = 8'h00;

      // Reset values
      step(2);
      check("rst_fifo_rd", bus.fifo_rd, 1'b0);
      check("rst_m_valid", bus.m_valid, 1'b0);
      check("rst_m_data", bus.m_data, 8'h00);
      check("rst_busy", busy, 1'b0);
      check("rst_underflow", underflow_err, 1'b0);
      check("rst_state", state_dbg, 2'd0);
      rst_n = 1'b1;
      step(2);

      // Burst: 6 bytes, 4 read back-to-back, first beat 3 edges after trigger
      for (int i = 0; i < 6; i++)
         push_fifo(8'(8'h10 + i), i < BURST_LEN);
      rd_base = rd_pulses;
      chk_gap = 1'b1;
      c0 = cyc;
      pulse_threshold();
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (bus.m_valid) break;
      end
      check("first_valid_lat", cyc - c0, 3);
      step(1);
      wait_done("burst_done", 40);
      chk_gap = 1'b0;
      check("burst_reads", rd_pulses - rd_base, BURST_LEN);
      check("burst_state", state_dbg, 2'd0);
      check("burst_left", bus.fifo_empty, 1'b0);
      clear_fifo();

      // Backpressure: m_ready low for 5 cycles
      for (int i = 0; i < 6; i++)
         push_fifo(8'(8'h10 + i), i < BURST_LEN);
      bus.m_ready = 1'b0;
      rd_base = rd_pulses;
      pulse_threshold();
      step(4);
      check("bp_reads_le2", (rd_pulses - rd_base) <= 2, 1'b1);
      check("bp_valid", bus.m_valid, 1'b1);
      check("bp_data", bus.m_data, 8'h10);
      bus.m_ready = 1'b1;
      wait_done("bp_done", 40);
      check("bp_reads", rd_pulses - rd_base, BURST_LEN);
      clear_fifo();

      // Flush: 3 bytes drained completely
      for (int i = 0; i < 3; i++)
         push_fifo(8'(8'hA0 + i), 1'b1);
      rd_base = rd_pulses;
      pulse_flush();
      wait_done("flush_done", 40);
      check("flush_reads", rd_pulses - rd_base, 3);
      check("flush_empty", bus.fifo_empty, 1'b1);
      check("flush_busy", busy, 1'b0);

      // Stall: burst starts with 2 bytes, completes after 2 more arrive
      push_fifo(8'h30, 1'b1);
      push_fifo(8'h31, 1'b1);
      rd_base = rd_pulses;
      pulse_threshold();
      step(8);
      check("stall_reads", rd_pulses - rd_base, 2);
      check("stall_state", state_dbg, 2'd1);
      push_fifo(8'h32, 1'b1);
      push_fifo(8'h33, 1'b1);
      wait_done("stall_done", 40);
      check("stall_total", rd_pulses - rd_base, BURST_LEN);

      // Flush during burst: the pending flush empties the FIFO afterwards
      for (int i = 0; i < 8; i++)
         push_fifo(8'(8'h40 + i), 1'b1);
      rd_base = rd_pulses;
      pulse_threshold();
      step(1);
      check("fdb_in_burst", state_dbg, 2'd1);
      pulse_flush();
      wait_done("fdb_done", 80);
      check("fdb_reads", rd_pulses - rd_base, 8);
      check("fdb_empty", bus.fifo_empty, 1'b1);
      busy_cnt = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (busy) busy_cnt++;
      end
      check("fdb_pend_clear", busy_cnt, 0);
      step(1);

      // Reset while reads are in flight
      for (int i = 0; i < 6; i++)
         push_fifo(8'(8'h50 + i), 1'b0);
      pulse_threshold();
      seen = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (bus.fifo_rd) seen++;
         if (seen == 2) break;
      end
      check("mid_rd_seen", seen, 2);
      rst_n = 1'b0;
      #1;
      check("mid_rst_fifo_rd", bus.fifo_rd, 1'b0);
      check("mid_rst_m_valid", bus.m_valid, 1'b0);
      check("mid_rst_m_data", bus.m_data, 8'h00);
      check("mid_rst_busy", busy, 1'b0);
      check("mid_rst_state", state_dbg, 2'd0);
      step(2);
      rst_n = 1'b1;
      clear_fifo();
      beat_base = beats;
      busy_cnt = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (bus.m_valid) busy_cnt++;
      end
      check("post_rst_no_valid", busy_cnt, 0);
      check("post_rst_beats", beats - beat_base, 0);
      step(1);

      check("underflow_never", underflow_err, 1'b0);
      check("exp_q_empty", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/fifo_burst_reader.md
FIFO_BURST_READER -- requirements
Module: fifo_burst_reader

Interface
REQ-001 SHALL have parameter DATA_W, default 8, FIFO and output data width.
REQ-002 SHALL have parameter BURST_LEN, default 4, reads per threshold-triggered burst (range 1-255).
REQ-003 SHALL have port clk, input, 1, single clock; all logic on the rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port fifo_empty, input, 1, FIFO empty flag.
REQ-006 SHALL have port fifo_threshold, input, 1, FIFO threshold flag.
REQ-007 SHALL have port fifo_data, input, DATA_W, FIFO read data, valid the cycle after a read is issued.
REQ-008 SHALL have port fifo_rd, output, 1, FIFO read strobe, one read per high cycle.
REQ-009 SHALL have port flush, input, 1, single-cycle request to drain the FIFO completely.
REQ-010 SHALL have port m_valid, output, 1, downstream data valid.
REQ-011 SHALL have port m_ready, input, 1, downstream ready; transfer when m_valid and m_ready are both high.
REQ-012 SHALL have port m_data, output, DATA_W, downstream data.
REQ-013 SHALL have port busy, output, 1, high in any state other than IDLE.
REQ-014 SHALL have port underflow_err, output, 1, sticky; set if fifo_rd is high while fifo_empty is high.

Function
REQ-015 SHALL implement the states IDLE, BURST, FLUSH and DRAIN.
REQ-016 IDLE -> FLUSH SHALL occur when flush is high or flush_pend is set; this takes priority over a burst start.
REQ-017 IDLE -> BURST SHALL occur when fifo_threshold is high and fifo_empty is low.
REQ-018 BURST SHALL issue exactly BURST_LEN reads; after the last read is issued it SHALL go to DRAIN.
REQ-019 If fifo_empty is high in BURST before BURST_LEN reads, the block SHALL stall without reading and resume when fifo_empty falls.
REQ-020 FLUSH SHALL read until fifo_empty is high with no read in flight, then go to DRAIN.
REQ-021 DRAIN -> IDLE SHALL occur when the output buffer is empty and no read is in flight.
REQ-022 flush asserted outside IDLE SHALL set flush_pend; flush_pend SHALL clear on entry to FLUSH.
REQ-023 fifo_rd SHALL be combinational: high only in BURST or FLUSH, with fifo_empty low and (buffered entries + in-flight reads) < 2.
REQ-024 The output buffer SHALL be a 2-entry skid buffer, so a stalled m_ready never loses the data returned one cycle after a read.
REQ-025 fifo_data SHALL be captured into the buffer exactly 1 cycle after each fifo_rd.
REQ-026 m_data SHALL be the oldest buffered entry, and m_valid SHALL be high whenever the buffer is non-empty.
REQ-027 Output order SHALL equal FIFO read order.
REQ-028 When m_valid is high, m_valid and m_data SHALL hold stable until the handshake.
REQ-029 A capture and a downstream transfer in the same cycle SHALL leave the occupancy unchanged.
REQ-030 The burst counter SHALL be 8 bits, load 0 on BURST entry, increment per issued read, and never wrap.
REQ-031 The throughput limit SHALL be 1 beat/cycle with m_ready held high; first m_valid SHALL be 2 cycles after the IDLE exit edge.

Reset
REQ-032 When rst_n is low, the block SHALL asynchronously force state=IDLE, fifo_rd=0, m_valid=0, m_data=0, busy=0 and underflow_err=0.
REQ-033 Reset SHALL also clear the buffer, the in-flight flag, flush_pend and the burst counter.
REQ-034 Reset asserted mid-burst SHALL discard any in-flight data; no m_valid SHALL follow the reset release until a new trigger.
REQ-035 Reset release SHALL be synchronous to clk.

Verification
REQ-036 Burst: FIFO holds 6 bytes 0x10..0x15, threshold=1, m_ready=1 -> exactly 4 fifo_rd pulses; m_data 0x10..0x13 on consecutive cycles; then IDLE.
REQ-037 Backpressure: same as REQ-036 with m_ready=0 for 5 cycles -> at most 2 reads issued; m_data=0x10 held; then 0x11..0x13 in order with no loss.
REQ-038 Flush: FIFO holds 3 bytes 0xA0..0xA2, flush pulse -> 3 reads; outputs 0xA0, 0xA1, 0xA2; busy falls after the last transfer.
REQ-039 Stall: burst started with 2 bytes in FIFO -> 2 reads, stall while empty; 2 more bytes written -> burst completes with 4 beats.
REQ-040 Flush during burst: flush pulse mid-BURST -> burst completes, then FLUSH empties the FIFO without a second flush pulse.
REQ-041 Reset: rst_n low while fifo_rd is high -> all outputs 0 within the same cycle; no stale beat after release.
